// File: rtl/fib_regbank_seq.sv
// fib_regbank_seq: writes F(0)..F(n-1) into an external register bank (term F(k) at register k+1)
// using only the bank's write port and its two combinational read ports, then reports F(n-1) on result.
// Latency: done in cycle 2+2*(n_eff-2)+1 after start acceptance (INIT0 = cycle 1), one more with readback.
// Backpressure: none; start is sampled only in IDLE, so a start while busy or during DONE is dropped.
// Optional feature: define SEQ_READBACK_EN to add a CHECK state that re-reads the last term and flags error.
//
// Ports:
//   clk, arst                      clock and asynchronous active-high reset
//   start, n                       sequence request and term count (n < 2 is treated as 2)
//   read_data1/2, read_dir1/2      bank read ports (addresses out, data back combinationally)
//   write_en, write_dir, write_data bank write port
//   busy, done, result, error      status: busy span, one-cycle completion pulse, F(n_eff-1), readback flag
module fib_regbank_seq (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic [4:0]  n,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    output logic        write_en,
    output logic [4:0]  write_dir,
    output logic [31:0] write_data,
    output logic [4:0]  read_dir1,
    output logic [4:0]  read_dir2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        error
);

`ifdef SEQ_READBACK_EN
    typedef enum logic [2:0] {IDLE, INIT0, INIT1, READ, WRITE, CHECK, DONE} state_t;
    localparam state_t POST_WRITE = CHECK;
`else
    typedef enum logic [2:0] {IDLE, INIT0, INIT1, READ, WRITE, DONE} state_t;
    localparam state_t POST_WRITE = DONE;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  n_eff;
    logic [4:0]  k;          // index of the term currently being produced
    logic [4:0]  k_inc;
    logic [31:0] sum;
    logic [31:0] last_val;   // most recently written term, source for result and readback
    logic [31:0] result_q;

    assign k_inc = k + 5'd1;

    // Next-state and Moore outputs. Every bank-facing output defaults to 0 so that
    // only the states that own the bus drive it.
    always_comb begin
        state_nxt  = state;
        write_en   = 1'b0;
        write_dir  = 5'd0;
        write_data = 32'd0;
        read_dir1  = 5'd0;
        read_dir2  = 5'd0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = INIT0;
            end
            INIT0: begin
                write_en   = 1'b1;
                write_dir  = 5'd1;
                write_data = 32'd0;
                state_nxt  = INIT1;
            end
            INIT1: begin
                write_en   = 1'b1;
                write_dir  = 5'd2;
                write_data = 32'd1;
                state_nxt  = (n_eff > 5'd2) ? READ : POST_WRITE;
            end
            READ: begin
                // register k holds F(k-1), register k-1 holds F(k-2)
                read_dir1 = k;
                read_dir2 = k - 5'd1;
                state_nxt = WRITE;
            end
            WRITE: begin
                write_en   = 1'b1;
                write_dir  = k_inc;
                write_data = sum;
                // k is incremented on this edge, so test the incremented value
                state_nxt  = (k_inc < n_eff) ? READ : POST_WRITE;
            end
`ifdef SEQ_READBACK_EN
            CHECK: begin
                read_dir1 = n_eff;
                state_nxt = DONE;
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            n_eff    <= 5'd0;
            k        <= 5'd0;
            sum      <= 32'd0;
            last_val <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_eff <= (n < 5'd2) ? 5'd2 : n;
                        k     <= 5'd2;
                    end
                end
                INIT0: last_val <= 32'd0;
                INIT1: last_val <= 32'd1;
                READ:  sum      <= read_data1 + read_data2;
                WRITE: begin
                    last_val <= sum;
                    k        <= k_inc;
                end
                DONE:  result_q <= last_val;
                default: ;
            endcase
        end
    end

`ifdef SEQ_READBACK_EN
    logic error_q;

    // Sticky until the next accepted start.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            error_q <= 1'b0;
        end else if (state == IDLE && start) begin
            error_q <= 1'b0;
        end else if (state == CHECK && read_data1 != last_val) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign busy = (state != IDLE);
    // result shows the fresh value during the done pulse and is then held by result_q.
    assign result = (state == DONE) ? last_val : result_q;

endmodule

// File: tb/tb_fib_regbank_seq.sv
module tb_fib_regbank_seq;

`ifdef SEQ_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic [4:0]  n;
    logic [31:0] read_data1, read_data2;
    logic        write_en;
    logic [4:0]  write_dir;
    logic [31:0] write_data;
    logic [4:0]  read_dir1, read_dir2;
    logic        busy, done, error;
    logic [31:0] result;

    always #5 clk = ~clk;

    fib_regbank_seq dut (
        .clk(clk), .arst(arst), .start(start), .n(n),
        .read_data1(read_data1), .read_data2(read_data2),
        .write_en(write_en), .write_dir(write_dir), .write_data(write_data),
        .read_dir1(read_dir1), .read_dir2(read_dir2),
        .busy(busy), .done(done), .result(result), .error(error)
    );

    // Register bank model; corrupt flips bit 0 of anything written to register 10.
    logic [31:0] bank [32];
    logic        clr_bank = 1'b0;
    logic        corrupt  = 1'b0;

    always @(posedge clk) begin
        if (clr_bank) begin
            for (int i = 0; i < 32; i++) bank[i] <= 32'd0;
        end else if (write_en) begin
            bank[write_dir] <= (corrupt && write_dir == 5'd10) ? (write_data ^ 32'h1) : write_data;
        end
    end

    assign read_data1 = bank[read_dir1];
    assign read_data2 = bank[read_dir2];

    int checks   = 0;
    int failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fib(input int i);
        logic [31:0] a, b, t;
        a = 32'd0;
        b = 32'd1;
        for (int j = 0; j < i; j++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check32({tag, "_strobes"}, {28'd0, write_en, busy, done, error}, 32'd0);
        check32({tag, "_dirs"}, {17'd0, write_dir, read_dir1, read_dir2}, 32'd0);
        check32({tag, "_write_data"}, write_data, 32'd0);
        check32({tag, "_result"}, result, 32'd0);
    endtask

    typedef struct {
        logic [4:0]  n;
        logic [31:0] exp_result;
        int          exp_done;   // cycle of done, INIT0 = 1, without readback
        int          exp_neff;
        bit          poke_busy;  // pulse start with another n while busy
    } vec_t;

    vec_t vecs [7];

    // Must be called right after a falling edge.
    task automatic run_seq(input vec_t v, input bit corr, input bit exp_err, input string tag);
        int c, done_cyc, busy_cnt, writes, bad_regs;
        bit wr_zero;
        clr_bank = 1'b1;
        @(negedge clk);
        clr_bank = 1'b0;
        corrupt  = corr;
        n        = v.n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        c = 1; done_cyc = 0; busy_cnt = 0; writes = 0; wr_zero = 1'b0;
        while (c <= 200) begin
            if (busy) busy_cnt++;
            if (write_en) begin
                writes++;
                if (write_dir == 5'd0) wr_zero = 1'b1;
            end
            if (done) begin
                done_cyc = c;
                check32({tag, "_result_at_done"}, result, v.exp_result);
                check32({tag, "_error_at_done"}, {31'd0, error}, {31'd0, exp_err});
                break;
            end
            if (v.poke_busy && c == 4) begin
                start = 1'b1;
                n     = 5'd31;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check32({tag, "_done_cycle"}, done_cyc, v.exp_done + RB);
        check32({tag, "_busy_cycles"}, busy_cnt, v.exp_done + RB);
        check32({tag, "_write_count"}, writes, v.exp_neff);
        check32({tag, "_write_dir_zero"}, {31'd0, wr_zero}, 32'd0);
        if (!corr) begin
            bad_regs = 0;
            for (int i = 1; i <= v.exp_neff; i++)
                if (bank[i] !== fib(i - 1)) bad_regs++;
            if (bank[0] !== 32'd0) bad_regs++;
            check32({tag, "_bank_bad_regs"}, bad_regs, 0);
        end
        @(negedge clk);
        check32({tag, "_done_pulse_len"}, {31'd0, done}, 32'd0);
        check32({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check32({tag, "_result_held"}, result, v.exp_result);
        check32({tag, "_idle_bus"}, {16'd0, write_en, write_dir, read_dir1, read_dir2}, 32'd0);
        check32({tag, "_idle_wdata"}, write_data, 32'd0);
        corrupt = 1'b0;
    endtask

    initial begin
        int c;
        bit seen;
        vecs[0] = '{5'd0,  32'd1,      3,  2,  1'b0};
        vecs[1] = '{5'd1,  32'd1,      3,  2,  1'b0};
        vecs[2] = '{5'd2,  32'd1,      3,  2,  1'b0};
        vecs[3] = '{5'd3,  32'd1,      5,  3,  1'b0};
        vecs[4] = '{5'd10, 32'd34,     19, 10, 1'b1};
        vecs[5] = '{5'd31, 32'd832040, 61, 31, 1'b0};
        vecs[6] = '{5'd4,  32'd2,      7,  4,  1'b0};

        arst  = 1'b1;
        start = 1'b0;
        n     = 5'd0;
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        arst = 1'b0;

        // n=10 register contents against hand values
        for (int i = 0; i < 7; i++) run_seq(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d_n%0d", i, vecs[i].n));
        run_seq(vecs[4], 1'b0, 1'b0, "n10_again");
        check32("n10_reg10", bank[10], 32'd34);
        check32("n10_reg7", bank[7], 32'd8);
        check32("n10_reg11_untouched", bank[11], 32'd0);

        // start during DONE is dropped, then taken in the following IDLE cycle
        n     = 5'd3;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!done && c < 50) begin
            @(negedge clk);
            c++;
        end
        check32("done_start_seen_done", {31'd0, done}, 32'd1);
        n     = 5'd2;
        start = 1'b1;
        @(negedge clk);
        check32("done_start_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check32("done_start_accepted", {31'd0, busy}, 32'd1);
        check32("done_start_init0_dir", {27'd0, write_dir}, 32'd1);
        c = 0;
        while (!done && c < 50) begin
            @(negedge clk);
            c++;
        end
        check32("done_start_latency", c, 2 + RB);
        check32("done_start_result", result, 32'd1);
        @(negedge clk);

        // async reset during the WRITE of term 5 (register 6) with n=10
        clr_bank = 1'b1;
        @(negedge clk);
        clr_bank = 1'b0;
        n     = 5'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        seen = 1'b0;
        while (c < 50) begin
            if (write_en && write_dir == 5'd6) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            c++;
        end
        check32("rst_reached_term5", {31'd0, seen}, 32'd1);
        arst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        @(negedge clk);
        check_outputs_zero("rst_mid_held");
        check32("rst_no_write_reg6", bank[6], 32'd0);
        check32("rst_kept_reg5", bank[5], 32'd3);
        arst = 1'b0;
        run_seq(vecs[6], 1'b0, 1'b0, "after_rst_n4");

`ifdef SEQ_READBACK_EN
        run_seq(vecs[4], 1'b1, 1'b1, "rb_corrupt");
        run_seq(vecs[4], 1'b0, 1'b0, "rb_clean");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
